tuner_lock_sequencer: RTL and testbench



---
 rtl/tuner_lock_sequencer_if.sv | 57 +++++
 rtl/tuner_lock_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_tuner_lock_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tuner_lock_sequencer_if.sv
// Signal bundle between the tuner lock sequencer and its surroundings: host control,
// search engine report, and lock engine handshakes.
interface tuner_lock_sequencer_if #(
  parameter int DAC_WIDTH  = 8,
  parameter int ADC_WIDTH  = 8,
  parameter int NUM_TARGET = 8,
  parameter int RESUME_MAX = 2,
  parameter int SEARCH_MAX = 3
);
  localparam int IDX_W  = $clog2(NUM_TARGET);
  localparam int CNT_W  = IDX_W + 1;
  localparam int RES_W  = $clog2(RESUME_MAX + 1);
  localparam int SRCH_W = $clog2(SEARCH_MAX + 1);

  logic                                  start;
  logic [IDX_W-1:0]                      cfg_target_idx;
  logic [ADC_WIDTH-1:0]                  cfg_min_pwr;
  logic                                  search_trig_val;
  logic                                  search_trig_rdy;
  logic                                  search_peaks_val;
  logic                                  search_peaks_rdy;
  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0]  ring_tune_peaks;
  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0]  pwr_peaks;
  logic [CNT_W-1:0]                      peaks_cnt;
  logic [DAC_WIDTH-1:0]                  cfg_ring_tune_peak;
  logic [ADC_WIDTH-1:0]                  cfg_pwr_peak;
  logic                                  lock_trig_val;
  logic                                  lock_trig_rdy;
  logic                                  lock_intr_val;
  logic                                  lock_intr_rdy;
  logic                                  lock_resume_val;
  logic                                  lock_resume_rdy;
  logic [2:0]                            state;
  logic                                  locked;
  logic                                  err;
  logic [RES_W-1:0]                      resume_cnt;
  logic [SRCH_W-1:0]                     search_cnt;

  // master is the sequencer; slave is the host plus search/lock engines
  modport master (
    input  start, cfg_target_idx, cfg_min_pwr, search_trig_rdy, search_peaks_val,
           ring_tune_peaks, pwr_peaks, peaks_cnt, lock_trig_rdy, lock_intr_val,
           lock_resume_rdy,
    output search_trig_val, search_peaks_rdy, cfg_ring_tune_peak, cfg_pwr_peak,
           lock_trig_val, lock_intr_rdy, lock_resume_val, state, locked, err,
           resume_cnt, search_cnt
  );

  modport slave (
    output start, cfg_target_idx, cfg_min_pwr, search_trig_rdy, search_peaks_val,
           ring_tune_peaks, pwr_peaks, peaks_cnt, lock_trig_rdy, lock_intr_val,
           lock_resume_rdy,
    input  search_trig_val, search_peaks_rdy, cfg_ring_tune_peak, cfg_pwr_peak,
           lock_trig_val, lock_intr_rdy, lock_resume_val, state, locked, err,
           resume_cnt, search_cnt
  );
endinterface

// File: rtl/tuner_lock_sequencer.sv
// Sequences search -> peak select -> lock, and supervises the lock with bounded
// resume and re-search retries before declaring an error.
//
// state       | meaning
// IDLE        | waiting for start, counters cleared
// SEARCH_TRIG | requesting a search sweep
// SEARCH_WAIT | accepting the peak report
// SELECT      | picking the target peak (one cycle)
// LOCK_TRIG   | requesting lock on the selected peak
// LOCKED      | lock held, listening for loss-of-lock
// RESUME      | requesting a lock resume
// ERR         | retries exhausted, sticky until start
module tuner_lock_sequencer #(
  parameter int DAC_WIDTH  = 8,
  parameter int ADC_WIDTH  = 8,
  parameter int NUM_TARGET = 8,
  parameter int RESUME_MAX = 2,
  parameter int SEARCH_MAX = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  tuner_lock_sequencer_if.master     bus
);
  localparam int IDX_W  = $clog2(NUM_TARGET);
  localparam int CNT_W  = IDX_W + 1;
  localparam int RES_W  = $clog2(RESUME_MAX + 1);
  localparam int SRCH_W = $clog2(SEARCH_MAX + 1);

  localparam logic [CNT_W-1:0]  NT_CNT   = CNT_W'(NUM_TARGET);
  localparam logic [RES_W-1:0]  RES_LIM  = RES_W'(RESUME_MAX);
  localparam logic [SRCH_W-1:0] SRCH_LIM = SRCH_W'(SEARCH_MAX);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SEARCH_TRIG = 3'd1,
    SEARCH_WAIT = 3'd2,
    SELECT      = 3'd3,
    LOCK_TRIG   = 3'd4,
    LOCKED      = 3'd5,
    RESUME      = 3'd6,
    ERR         = 3'd7
  } state_t;

  state_t                               state, state_nxt;
  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] peak_tune;
  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] peak_pwr;
  logic [CNT_W-1:0]                     peak_cnt, cnt_clamped, qual_cnt;
  logic                                 found;
  logic [DAC_WIDTH-1:0]                 sel_tune, cfg_tune;
  logic [ADC_WIDTH-1:0]                 sel_pwr, cfg_pwr;
  logic [RES_W-1:0]                     resume_cnt;
  logic [SRCH_W-1:0]                    search_cnt;
  logic                                 resume_left, search_left;
  logic                                 search_trig_val, peaks_rdy, lock_trig_val;
  logic                                 intr_rdy, resume_val, locked, err;

  assign resume_left = (resume_cnt < RES_LIM);
  assign search_left = (search_cnt < SRCH_LIM);
  assign cnt_clamped = (bus.peaks_cnt > NT_CNT) ? NT_CNT : bus.peaks_cnt;

  // Walk peaks in ascending index, picking the target_idx-th one that qualifies.
  always_comb begin
    found    = 1'b0;
    sel_tune = '0;
    sel_pwr  = '0;
    qual_cnt = '0;
    for (int j = 0; j < NUM_TARGET; j++) begin
      if ((CNT_W'(j) < peak_cnt) && (peak_pwr[j] >= bus.cfg_min_pwr)) begin
        if (!found && (qual_cnt == {1'b0, bus.cfg_target_idx})) begin
          found    = 1'b1;
          sel_tune = peak_tune[j];
          sel_pwr  = peak_pwr[j];
        end
        qual_cnt = qual_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (bus.start) state_nxt = SEARCH_TRIG;
      SEARCH_TRIG: if (bus.search_trig_rdy) state_nxt = SEARCH_WAIT;
      SEARCH_WAIT: if (bus.search_peaks_val) state_nxt = SELECT;
      SELECT: begin
        if (found)            state_nxt = LOCK_TRIG;
        else if (search_left) state_nxt = SEARCH_TRIG;
        else                  state_nxt = ERR;
      end
      LOCK_TRIG:   if (bus.lock_trig_rdy) state_nxt = LOCKED;
      LOCKED: begin
        if (bus.lock_intr_val) begin
          if (resume_left)      state_nxt = RESUME;
          else if (search_left) state_nxt = SEARCH_TRIG;
          else                  state_nxt = ERR;
        end
      end
      RESUME:      if (bus.lock_resume_rdy) state_nxt = LOCKED;
      ERR:         if (bus.start) state_nxt = SEARCH_TRIG;
      default:     state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      search_trig_val <= 1'b0;
      peaks_rdy       <= 1'b0;
      lock_trig_val   <= 1'b0;
      intr_rdy        <= 1'b0;
      resume_val      <= 1'b0;
      locked          <= 1'b0;
      err             <= 1'b0;
      resume_cnt      <= '0;
      search_cnt      <= '0;
      peak_tune       <= '0;
      peak_pwr        <= '0;
      peak_cnt        <= '0;
      cfg_tune        <= '0;
      cfg_pwr         <= '0;
    end else begin
      state           <= state_nxt;
      search_trig_val <= (state_nxt == SEARCH_TRIG);
      peaks_rdy       <= (state_nxt == SEARCH_WAIT);
      lock_trig_val   <= (state_nxt == LOCK_TRIG);
      intr_rdy        <= (state_nxt == LOCKED);
      resume_val      <= (state_nxt == RESUME);
      locked          <= (state_nxt == LOCKED);
      err             <= (state_nxt == ERR);
      case (state)
        IDLE: begin
          resume_cnt <= '0;
          search_cnt <= '0;
        end
        ERR: begin
          if (bus.start) begin
            resume_cnt <= '0;
            search_cnt <= '0;
          end
        end
        SEARCH_TRIG: begin
          if (bus.search_trig_rdy) begin
            search_cnt <= search_cnt + 1'b1;
            resume_cnt <= '0;
          end
        end
        SEARCH_WAIT: begin
          if (bus.search_peaks_val) begin
            peak_tune <= bus.ring_tune_peaks;
            peak_pwr  <= bus.pwr_peaks;
            peak_cnt  <= cnt_clamped;
          end
        end
        SELECT: begin
          if (found) begin
            cfg_tune <= sel_tune;
            cfg_pwr  <= sel_pwr;
          end
        end
        LOCKED: begin
          if (bus.lock_intr_val && resume_left) resume_cnt <= resume_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state              = state;
  assign bus.search_trig_val    = search_trig_val;
  assign bus.search_peaks_rdy   = peaks_rdy;
  assign bus.lock_trig_val      = lock_trig_val;
  assign bus.lock_intr_rdy      = intr_rdy;
  assign bus.lock_resume_val    = resume_val;
  assign bus.locked             = locked;
  assign bus.err                = err;
  assign bus.resume_cnt         = resume_cnt;
  assign bus.search_cnt         = search_cnt;
  assign bus.cfg_ring_tune_peak = cfg_tune;
  assign bus.cfg_pwr_peak       = cfg_pwr;
endmodule

// File: tb/tb_tuner_lock_sequencer.sv
// Directed plus randomized bench for tuner_lock_sequencer, checked against a
// transaction-level model of search counting, peak selection and retry limits.
module tb_tuner_lock_sequencer;
  localparam int NT         = 8;
  localparam int RESUME_MAX = 2;
  localparam int SEARCH_MAX = 3;

  typedef logic [NT-1:0][7:0] peaks_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_miscmp = 0;

  int   m_search, m_resume;
  int   m_tune, m_pwr;

  tuner_lock_sequencer_if #(.DAC_WIDTH(8), .ADC_WIDTH(8), .NUM_TARGET(NT),
                            .RESUME_MAX(RESUME_MAX), .SEARCH_MAX(SEARCH_MAX)) bus ();

  tuner_lock_sequencer #(.DAC_WIDTH(8), .ADC_WIDTH(8), .NUM_TARGET(NT),
                         .RESUME_MAX(RESUME_MAX), .SEARCH_MAX(SEARCH_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec rule: qualifying = index < min(cnt, NT) and pwr >= min; pick the tidx-th.
  function automatic int model_pick(input peaks_t pw, input int cnt, input int minp,
                                    input int tidx);
    int q[$];
    int eff;
    eff = (cnt > NT) ? NT : cnt;
    for (int j = 0; j < eff; j++)
      if (int'(pw[j]) >= minp) q.push_back(j);
    return (tidx < q.size()) ? q[tidx] : -1;
  endfunction

  task automatic zero_check();
    chk("rst_state", bus.state, 0);
    chk("rst_trig_val", bus.search_trig_val, 0);
    chk("rst_peaks_rdy", bus.search_peaks_rdy, 0);
    chk("rst_lock_val", bus.lock_trig_val, 0);
    chk("rst_intr_rdy", bus.lock_intr_rdy, 0);
    chk("rst_resume_val", bus.lock_resume_val, 0);
    chk("rst_cfg_tune", bus.cfg_ring_tune_peak, 0);
    chk("rst_cfg_pwr", bus.cfg_pwr_peak, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_resume_cnt", bus.resume_cnt, 0);
    chk("rst_search_cnt", bus.search_cnt, 0);
  endtask

  // Called at posedge+1; reset asserts mid-cycle, well before the next edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 zero_check();
    tick();
    tick();
    rst = 1'b0;
    m_search = 0; m_resume = 0; m_tune = 0; m_pwr = 0;
    tick();
    chk("post_rst_idle", bus.state, 0);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_search = 0; m_resume = 0;
    chk("start_state", bus.state, 1);
    chk("start_trig_val", bus.search_trig_val, 1);
    chk("start_search_cnt", bus.search_cnt, 0);
  endtask

  task automatic search_handshake(input int delay);
    chk("strig_val", bus.search_trig_val, 1);
    chk("strig_state", bus.state, 1);
    repeat (delay) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.lock_intr_val = 1'($urandom_range(0, 1));
      tick();
      chk("strig_val_hold", bus.search_trig_val, 1);
      chk("strig_state_hold", bus.state, 1);
      chk("intr_rdy_outside", bus.lock_intr_rdy, 0);
    end
    bus.start = 1'b0;
    bus.lock_intr_val = 1'b0;
    bus.search_trig_rdy = 1'b1;
    tick();
    bus.search_trig_rdy = 1'b0;
    m_search++;
    m_resume = 0;
    chk("swait_state", bus.state, 2);
    chk("strig_val_drop", bus.search_trig_val, 0);
    chk("peaks_rdy", bus.search_peaks_rdy, 1);
    chk("search_cnt", bus.search_cnt, m_search);
    chk("resume_cnt_clr", bus.resume_cnt, m_resume);
  endtask

  task automatic peak_report(input peaks_t t, input peaks_t p, input int cnt, input int minp,
                             input int tidx, input int delay, output int pick);
    bus.cfg_min_pwr    = 8'(minp);
    bus.cfg_target_idx = 3'(tidx);
    repeat (delay) begin
      tick();
      chk("peaks_rdy_hold", bus.search_peaks_rdy, 1);
      chk("swait_hold", bus.state, 2);
    end
    bus.ring_tune_peaks  = t;
    bus.pwr_peaks        = p;
    bus.peaks_cnt        = 4'(cnt);
    bus.search_peaks_val = 1'b1;
    tick();
    bus.search_peaks_val = 1'b0;
    bus.ring_tune_peaks  = {$urandom, $urandom};
    bus.pwr_peaks        = {$urandom, $urandom};
    bus.peaks_cnt        = 4'($urandom);
    chk("select_state", bus.state, 3);
    chk("peaks_rdy_drop", bus.search_peaks_rdy, 0);
    pick = model_pick(p, cnt, minp, tidx);
    if (pick >= 0) begin
      m_tune = int'(t[pick]);
      m_pwr  = int'(p[pick]);
    end
    tick();
    bus.cfg_min_pwr    = 8'($urandom);
    bus.cfg_target_idx = 3'($urandom);
    chk("cfg_tune", bus.cfg_ring_tune_peak, m_tune);
    chk("cfg_pwr", bus.cfg_pwr_peak, m_pwr);
    if (pick >= 0) begin
      chk("ltrig_state", bus.state, 4);
      chk("ltrig_val", bus.lock_trig_val, 1);
    end else begin
      chk("nf_state", bus.state, (m_search < SEARCH_MAX) ? 1 : 7);
      chk("nf_err", bus.err, (m_search < SEARCH_MAX) ? 0 : 1);
    end
  endtask

  task automatic lock_handshake(input int delay);
    chk("ltrig_val_pre", bus.lock_trig_val, 1);
    repeat (delay) begin
      tick();
      chk("ltrig_val_hold", bus.lock_trig_val, 1);
      chk("ltrig_state_hold", bus.state, 4);
      chk("cfg_tune_hold", bus.cfg_ring_tune_peak, m_tune);
    end
    bus.lock_trig_rdy = 1'b1;
    tick();
    bus.lock_trig_rdy = 1'b0;
    chk("locked_state", bus.state, 5);
    chk("locked_flag", bus.locked, 1);
    chk("intr_rdy", bus.lock_intr_rdy, 1);
    chk("ltrig_val_drop", bus.lock_trig_val, 0);
  endtask

  task automatic interrupt(input int dly, input int rdly, output int nxt);
    repeat (dly) begin
      bus.start = 1'($urandom_range(0, 1));
      tick();
      chk("locked_hold", bus.state, 5);
      chk("locked_flag_hold", bus.locked, 1);
    end
    bus.start = 1'b0;
    bus.lock_intr_val = 1'b1;
    tick();
    bus.lock_intr_val = 1'b0;
    if (m_resume < RESUME_MAX) begin
      m_resume++;
      chk("resume_state", bus.state, 6);
      chk("resume_val", bus.lock_resume_val, 1);
      chk("resume_cnt", bus.resume_cnt, m_resume);
      repeat (rdly) begin
        tick();
        chk("resume_val_hold", bus.lock_resume_val, 1);
      end
      bus.lock_resume_rdy = 1'b1;
      tick();
      bus.lock_resume_rdy = 1'b0;
      chk("relock_state", bus.state, 5);
      chk("resume_val_drop", bus.lock_resume_val, 0);
      nxt = 5;
    end else if (m_search < SEARCH_MAX) begin
      chk("research_state", bus.state, 1);
      nxt = 1;
    end else begin
      chk("exhaust_state", bus.state, 7);
      chk("exhaust_err", bus.err, 1);
      nxt = 7;
    end
  endtask

  task automatic run_session(input int n_intr);
    int     pick, nxt;
    bit     done;
    peaks_t t, p;
    do_start();
    done = 0;
    nxt  = 1;
    while (!done) begin
      search_handshake($urandom_range(0, 3));
      t = {$urandom, $urandom};
      p = {$urandom, $urandom};
      peak_report(t, p, $urandom_range(0, 12), $urandom_range(0, 160),
                  $urandom_range(0, 3), $urandom_range(0, 2), pick);
      if (pick < 0) begin
        if (m_search >= SEARCH_MAX) done = 1;
      end else begin
        lock_handshake($urandom_range(0, 3));
        nxt = 5;
        for (int i = 0; i < n_intr && nxt == 5; i++)
          interrupt($urandom_range(0, 3), $urandom_range(0, 2), nxt);
        if (nxt != 1) done = 1;
      end
    end
    async_reset();
  endtask

  initial begin
    int     pick, nxt;
    peaks_t tp_t, tp_p, big_t, big_p;
    bus.start = 0; bus.cfg_target_idx = 0; bus.cfg_min_pwr = 0;
    bus.search_trig_rdy = 0; bus.search_peaks_val = 0;
    bus.ring_tune_peaks = '0; bus.pwr_peaks = '0; bus.peaks_cnt = 0;
    bus.lock_trig_rdy = 0; bus.lock_intr_val = 0; bus.lock_resume_rdy = 0;
    m_search = 0; m_resume = 0; m_tune = 0; m_pwr = 0;
    repeat (3) @(posedge clk);
    #1 zero_check();
    rst = 1'b0;
    tick();
    chk("idle_state", bus.state, 0);

    // Nominal report: second qualifying peak is entry 2.
    tp_t = '0; tp_p = '0;
    tp_t[0] = 8'd40; tp_t[1] = 8'd90; tp_t[2] = 8'd150;
    tp_p[0] = 8'd20; tp_p[1] = 8'd80; tp_p[2] = 8'd70;
    do_start();
    search_handshake(0);
    peak_report(tp_t, tp_p, 3, 50, 1, 0, pick);
    chk("tp_tune150", bus.cfg_ring_tune_peak, 150);
    chk("tp_pwr70", bus.cfg_pwr_peak, 70);
    lock_handshake(0);
    chk("tp_search1", bus.search_cnt, 1);

    // Three interrupts: two resumes then a re-search with a stalled trigger.
    interrupt(1, 0, nxt);
    interrupt(2, 1, nxt);
    chk("tp_resume2", bus.resume_cnt, 2);
    interrupt(0, 0, nxt);
    search_handshake(10);
    chk("tp_search2", bus.search_cnt, 2);
    chk("tp_resume0", bus.resume_cnt, 0);

    // Unreachable target index exhausts searches into ERR.
    peak_report(tp_t, tp_p, 3, 50, 2, 0, pick);
    search_handshake(0);
    peak_report(tp_t, tp_p, 3, 50, 2, 1, pick);
    chk("tp_err", bus.err, 1);
    repeat (3) begin
      bus.lock_intr_val = 1'b1;
      tick();
      chk("err_sticky", bus.state, 7);
      chk("err_no_intr_rdy", bus.lock_intr_rdy, 0);
    end
    bus.lock_intr_val = 1'b0;
    chk("err_cfg_held", bus.cfg_ring_tune_peak, 150);
    do_start();
    search_handshake(0);
    chk("restart_search1", bus.search_cnt, 1);

    // Oversized count clamps to NT; target 7 is the last entry.
    big_t = {$urandom, $urandom};
    big_p = '0;
    for (int j = 0; j < NT; j++) big_p[j] = 8'(200 + j);
    peak_report(big_t, big_p, 12, 100, 7, 0, pick);
    chk("clamp_tune", bus.cfg_ring_tune_peak, int'(big_t[7]));
    chk("clamp_pwr", bus.cfg_pwr_peak, 207);

    // Asynchronous reset while the lock trigger is pending.
    async_reset();

    // Start is ignored while locked.
    do_start();
    search_handshake(0);
    peak_report(tp_t, tp_p, 3, 50, 0, 0, pick);
    lock_handshake(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_ignored", bus.state, 5);
    chk("start_ignored_cnt", bus.search_cnt, 1);
    async_reset();

    for (int s = 0; s < 40; s++) run_session($urandom_range(1, 4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule
